// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//   Shares the single physical-memory (cacheline adaptor) port between the
//   I-cache miss path and the D-cache miss/writeback path. One requester is
//   granted at a time and holds the port until mem_resp; a single DONE cycle
//   then lets the finished cache drop its request before re-arbitration.
//   D-cache wins ties by default; a skip counter bounds low-priority starvation.
//
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   i_pmem_read/address               I-cache line read request
//   i_pmem_rdata/resp                 line data / completion pulse to I-cache
//   d_pmem_read/write/address/wdata   D-cache line read / writeback request
//   d_pmem_rdata/resp                 line data / completion pulse to D-cache
//   mem_read/write/address/wdata      command to cacheline adaptor
//   mem_rdata/resp                    data / completion pulse from adaptor
// -----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int LINE_W          = 256,
  parameter bit DCACHE_PRIORITY = 1'b1,
  parameter int MAX_SKIP        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [31:0]       i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [31:0]       d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int SKIP_W = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Grant states of the high- and low-priority sides.
  localparam state_t ST_HP = DCACHE_PRIORITY ? ST_GRANT_D : ST_GRANT_I;
  localparam state_t ST_LP = DCACHE_PRIORITY ? ST_GRANT_I : ST_GRANT_D;

  state_t              r_state;
  state_t              w_state_next;
  logic [SKIP_W-1:0]   r_skip_cnt;
  logic [SKIP_W-1:0]   w_skip_next;

  logic w_i_req;
  logic w_d_req;
  logic w_hp_req;
  logic w_lp_req;
  logic w_lp_forced;

  assign w_i_req     = i_pmem_read;
  assign w_d_req     = d_pmem_read | d_pmem_write;
  assign w_hp_req    = DCACHE_PRIORITY ? w_d_req : w_i_req;
  assign w_lp_req    = DCACHE_PRIORITY ? w_i_req : w_d_req;
  assign w_lp_forced = (r_skip_cnt == SKIP_W'(MAX_SKIP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_skip_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_skip_cnt <= w_skip_next;
    end
  end

  // Outputs are decoded purely from the current state so that an
  // asynchronous reset drops every command without waiting for a clock.
  always_comb begin
    w_state_next = r_state;
    w_skip_next  = r_skip_cnt;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_wdata    = '0;
    i_pmem_rdata = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_hp_req && !(w_lp_req && w_lp_forced)) begin
          w_state_next = ST_HP;
          // Low side loses only when it was actually waiting; otherwise it
          // has no pending debt and the counter restarts.
          if (w_lp_req) begin
            if (!w_lp_forced) w_skip_next = r_skip_cnt + 1'b1;
          end else begin
            w_skip_next = '0;
          end
        end else if (w_lp_req) begin
          w_state_next = ST_LP;
          w_skip_next  = '0;
        end
      end

      ST_GRANT_I: begin
        mem_read     = 1'b1;
        mem_address  = i_pmem_address & LINE_MASK;
        i_pmem_rdata = mem_rdata;
        i_pmem_resp  = mem_resp;
        if (mem_resp) w_state_next = ST_DONE;
      end

      ST_GRANT_D: begin
        // A writeback wins over a read if a cache raises both.
        mem_write    = d_pmem_write;
        mem_read     = d_pmem_read & ~d_pmem_write;
        mem_address  = d_pmem_address & LINE_MASK;
        mem_wdata    = d_pmem_wdata;
        d_pmem_rdata = mem_rdata;
        d_pmem_resp  = mem_resp;
        if (mem_resp) w_state_next = ST_DONE;
      end

      ST_DONE: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
//   Directed bench for pmem_arbiter: single I-miss, D-priority tie, starvation
//   bound, spurious response, D read+write, asynchronous reset mid-grant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pmem_arbiter;

  localparam int LINE_W = 256;

  logic              clk;
  logic              rst;
  logic              i_pmem_read;
  logic [31:0]       i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [31:0]       d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  int n_tests;
  int n_fail;

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] pat_wb;
  logic [LINE_W-1:0] pat_3c;

  pmem_arbiter #(
    .LINE_W(LINE_W),
    .DCACHE_PRIORITY(1'b1),
    .MAX_SKIP(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_pmem_read(i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata),
    .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read),
    .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata),
    .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".mem_read"},  mem_read,  1'b0);
    check({tag, ".mem_write"}, mem_write, 1'b0);
    check({tag, ".i_resp"},    i_pmem_resp, 1'b0);
    check({tag, ".d_resp"},    d_pmem_resp, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pat_a5  = {32{8'hA5}};
    pat_wb  = {32{8'h5A}};
    pat_3c  = {32{8'h3C}};

    rst            = 1'b1;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    mem_rdata      = '0;
    mem_resp       = 1'b0;

    // ---------------- reset state ----------------
    tick();
    i_pmem_read = 1'b1;  // requests during reset must not grant
    settle();
    check("rst.mem_read",    mem_read,    1'b0);
    check("rst.mem_write",   mem_write,   1'b0);
    check("rst.mem_address", mem_address, '0);
    check("rst.mem_wdata",   mem_wdata,   '0);
    check("rst.i_rdata",     i_pmem_rdata, '0);
    check("rst.d_rdata",     d_pmem_rdata, '0);
    i_pmem_read = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    check_quiet("post_rst");

    // ---------------- single I-miss ----------------
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0064;
    settle();
    check("imiss.idle_no_cmd", mem_read, 1'b0);
    tick();
    check("imiss.mem_read",    mem_read,    1'b1);
    check("imiss.mem_write",   mem_write,   1'b0);
    check("imiss.mem_address", mem_address, 32'h0000_0060);
    check("imiss.i_resp_wait", i_pmem_resp, 1'b0);
    mem_rdata = pat_a5;
    mem_resp  = 1'b1;
    settle();
    check("imiss.i_resp",  i_pmem_resp,  1'b1);
    check("imiss.i_rdata", i_pmem_rdata, pat_a5);
    check("imiss.d_resp",  d_pmem_resp,  1'b0);
    check("imiss.d_rdata", d_pmem_rdata, '0);
    tick();  // DONE
    mem_resp    = 1'b0;
    settle();
    check_quiet("imiss.done");
    i_pmem_read = 1'b0;
    tick();  // IDLE
    check_quiet("imiss.idle");

    // ---------------- simultaneous I-read + D-write ----------------
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_0240;
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_0100;
    d_pmem_wdata   = pat_wb;
    tick();
    check("tie.d_mem_write", mem_write,   1'b1);
    check("tie.d_mem_read",  mem_read,    1'b0);
    check("tie.d_address",   mem_address, 32'h0000_0100);
    check("tie.d_wdata",     mem_wdata,   pat_wb);
    mem_resp = 1'b1;
    settle();
    check("tie.d_resp", d_pmem_resp, 1'b1);
    check("tie.i_resp", i_pmem_resp, 1'b0);
    tick();  // DONE
    mem_resp     = 1'b0;
    d_pmem_write = 1'b0;
    settle();
    check_quiet("tie.done");
    tick();  // IDLE, I still requesting
    check("tie.idle_no_cmd", mem_read, 1'b0);
    tick();
    check("tie.i_mem_read", mem_read,    1'b1);
    check("tie.i_address",  mem_address, 32'h0000_0240);
    mem_rdata = pat_3c;
    mem_resp  = 1'b1;
    settle();
    check("tie.i_resp2",  i_pmem_resp,  1'b1);
    check("tie.i_rdata2", i_pmem_rdata, pat_3c);
    tick();
    mem_resp    = 1'b0;
    i_pmem_read = 1'b0;
    tick();  // IDLE

    // ---------------- spurious response in IDLE ----------------
    mem_resp = 1'b1;
    settle();
    check_quiet("spur");
    check("spur.i_rdata", i_pmem_rdata, '0);
    tick();
    mem_resp = 1'b0;
    settle();
    check_quiet("spur.still_idle");

    // ---------------- starvation bound ----------------
    i_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_1000;
    for (int k = 0; k < 3; k++) begin
      d_pmem_read    = 1'b1;
      d_pmem_address = 32'h0000_2000 + 32'(k * 32);
      tick();
      check($sformatf("starve%0d.d_mem_read", k), mem_read,    1'b1);
      check($sformatf("starve%0d.d_address", k),  mem_address, 32'h0000_2000 + 32'(k * 32));
      mem_resp = 1'b1;
      settle();
      check($sformatf("starve%0d.d_resp", k), d_pmem_resp, 1'b1);
      check($sformatf("starve%0d.i_resp", k), i_pmem_resp, 1'b0);
      tick();  // DONE
      mem_resp    = 1'b0;
      d_pmem_read = 1'b0;
      tick();  // IDLE
    end
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_3000;
    tick();  // 4th arbitration: I forced
    check("starve3.i_address", mem_address, 32'h0000_1000);
    mem_resp = 1'b1;
    settle();
    check("starve3.i_resp", i_pmem_resp, 1'b1);
    check("starve3.d_resp", d_pmem_resp, 1'b0);
    tick();  // DONE
    mem_resp = 1'b0;
    tick();  // IDLE, both still requesting; counter was cleared so D wins
    tick();
    check("starve.cleared_d_address", mem_address, 32'h0000_3000);
    mem_resp = 1'b1;
    settle();
    check("starve.cleared_d_resp", d_pmem_resp, 1'b1);
    tick();
    mem_resp    = 1'b0;
    d_pmem_read = 1'b0;
    i_pmem_read = 1'b0;
    tick();  // IDLE

    // ---------------- D read + write both high ----------------
    d_pmem_read    = 1'b1;
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_0480;
    d_pmem_wdata   = pat_3c;
    tick();
    check("rw.mem_write", mem_write, 1'b1);
    check("rw.mem_read",  mem_read,  1'b0);
    check("rw.wdata",     mem_wdata, pat_3c);
    mem_resp = 1'b1;
    settle();
    check("rw.d_resp", d_pmem_resp, 1'b1);
    tick();
    mem_resp     = 1'b0;
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    tick();  // IDLE

    // ---------------- async reset mid-grant ----------------
    d_pmem_write   = 1'b1;
    d_pmem_address = 32'h0000_0520;
    d_pmem_wdata   = pat_wb;
    tick();
    check("arst.pre_mem_write", mem_write, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.mem_write_fell", mem_write,   1'b0);
    check("arst.mem_address",    mem_address, '0);
    check("arst.mem_wdata",      mem_wdata,   '0);
    d_pmem_write = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
    check_quiet("arst.idle");
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_0600;
    tick();
    check("arst.regrant_read", mem_read,    1'b1);
    check("arst.regrant_addr", mem_address, 32'h0000_0600);
    mem_rdata = pat_a5;
    mem_resp  = 1'b1;
    settle();
    check("arst.d_resp",  d_pmem_resp,  1'b1);
    check("arst.d_rdata", d_pmem_rdata, pat_a5);
    tick();
    mem_resp    = 1'b0;
    d_pmem_read = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
